// File: rtl/image_pixel_proc.sv
// Streaming RGB point-operation engine: one WIDTH x HEIGHT frame per start,
// PPC pixels per beat, valid/ready on both sides, two-stage pipeline.
module image_pixel_proc #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int DW     = 8,
  parameter int PPC    = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  start,
  input  logic [2:0]            cfg_mode,
  input  logic [DW-1:0]         cfg_value,
  input  logic [DW-1:0]         cfg_threshold,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3*DW*PPC-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3*DW*PPC-1:0]   out_data,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic                  busy,
  output logic                  ctrl_done
);

  localparam int BW = 3*DW*PPC;
  localparam int SW = DW+2;
  localparam int CW = $clog2(WIDTH+1);
  localparam int RW = $clog2(HEIGHT+1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH-PPC);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT-1);
  localparam logic [DW-1:0] MAX      = '1;
  localparam logic [SW-1:0] THREE    = SW'(3);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [2:0]    mode_q, mode_d;
  logic [DW-1:0] value_q, value_d;
  logic [DW-1:0] thr_q, thr_d;

  logic              s1_valid_q, s1_valid_d;
  logic [BW-1:0]     s1_data_q, s1_data_d;
  logic [SW*PPC-1:0] s1_sum_q, s1_sum_d;
  logic              s1_eol_q, s1_eol_d;
  logic              s1_eof_q, s1_eof_d;

  logic          out_valid_q, out_valid_d;
  logic [BW-1:0] out_data_q, out_data_d;
  logic          out_eol_q, out_eol_d;
  logic          out_eof_q, out_eof_d;

  logic              advance;
  logic              accept;
  logic              beat_eol;
  logic              beat_eof;
  logic [SW*PPC-1:0] in_sum;
  logic [BW-1:0]     proc_data;

  // Per-pixel operation; component k=0 is B, k=2 is R.
  function automatic logic [3*DW-1:0] pix_op(
    input logic [3*DW-1:0] p,
    input logic [SW-1:0]   sum,
    input logic [2:0]      mode,
    input logic [DW-1:0]   val,
    input logic [DW-1:0]   thr
  );
    logic [DW-1:0]   grey;
    logic [DW-1:0]   c;
    logic [DW-1:0]   res;
    logic [DW:0]     wide;
    logic [3*DW-1:0] r;
    grey = DW'(sum / THREE);
    r    = p;
    for (int k = 0; k < 3; k++) begin
      c    = p[k*DW +: DW];
      wide = {1'b0, c} + {1'b0, val};
      case (mode)
        3'd1:    res = wide[DW] ? MAX : wide[DW-1:0];
        3'd2:    res = (c > val) ? (c - val) : '0;
        3'd3:    res = MAX - grey;
        3'd4:    res = (grey > thr) ? MAX : '0;
        default: res = c;
      endcase
      r[k*DW +: DW] = res;
    end
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < PPC; gi++) begin : g_pix
      assign in_sum[gi*SW +: SW] = SW'(in_data[gi*3*DW + 2*DW +: DW])
                                 + SW'(in_data[gi*3*DW + DW +: DW])
                                 + SW'(in_data[gi*3*DW +: DW]);
      assign proc_data[gi*3*DW +: 3*DW] = pix_op(s1_data_q[gi*3*DW +: 3*DW],
                                                 s1_sum_q[gi*SW +: SW],
                                                 mode_q, value_q, thr_q);
    end
  endgenerate

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = (state_q == ST_RUN) && advance;
  assign accept    = in_valid && in_ready;
  assign beat_eol  = (col_q == COL_LAST);
  assign beat_eof  = beat_eol && (row_q == ROW_LAST);
  // Completion is combinational with the final output handshake.
  assign ctrl_done = (state_q == ST_FLUSH) && out_valid_q && out_ready && out_eof_q;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    mode_d  = mode_q;
    value_d = value_q;
    thr_d   = thr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mode_d  = cfg_mode;
          value_d = cfg_value;
          thr_d   = cfg_threshold;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (beat_eol) begin
            col_d = '0;
            row_d = beat_eof ? '0 : row_q + RW'(1);
            if (beat_eof) state_d = ST_FLUSH;
          end else begin
            col_d = col_q + CW'(PPC);
          end
        end
      end
      ST_FLUSH: begin
        if (ctrl_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_sum_d    = s1_sum_q;
    s1_eol_d    = s1_eol_q;
    s1_eof_d    = s1_eof_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_eol_d   = out_eol_q;
    out_eof_d   = out_eof_q;
    if (advance) begin
      s1_valid_d  = accept;
      s1_data_d   = in_data;
      s1_sum_d    = in_sum;
      s1_eol_d    = accept && beat_eol;
      s1_eof_d    = accept && beat_eof;
      out_valid_d = s1_valid_q;
      out_data_d  = proc_data;
      out_eol_d   = s1_eol_q;
      out_eof_d   = s1_eof_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= '0;
      value_q     <= '0;
      thr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_sum_q    <= '0;
      s1_eol_q    <= 1'b0;
      s1_eof_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      value_q     <= value_d;
      thr_q       <= thr_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_sum_q    <= s1_sum_d;
      s1_eol_q    <= s1_eol_d;
      s1_eof_q    <= s1_eof_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_eol_q   <= out_eol_d;
      out_eof_q   <= out_eof_d;
    end
  end

endmodule

// File: tb/tb_image_pixel_proc.sv
// Randomised bench for image_pixel_proc on a tiny 8x2 frame, checked against
// an arithmetic reference model and a beat scoreboard.
module tb_image_pixel_proc;

  localparam int W     = 8;
  localparam int H     = 2;
  localparam int DW    = 8;
  localparam int PPC   = 2;
  localparam int BW    = 3*DW*PPC;
  localparam int BPL   = W/PPC;
  localparam int BEATS = W*H/PPC;

  typedef struct {
    logic [BW-1:0] data;
    logic          eol;
    logic          eof;
    int            cyc;
  } exp_t;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    cfg_mode = '0;
  logic [DW-1:0] cfg_value = '0;
  logic [DW-1:0] cfg_threshold = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_data;
  logic          out_eol;
  logic          out_eof;
  logic          busy;
  logic          ctrl_done;

  int n_cmp = 0;
  int n_bad = 0;

  image_pixel_proc #(.WIDTH(W), .HEIGHT(H), .DW(DW), .PPC(PPC)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .cfg_mode(cfg_mode),
    .cfg_value(cfg_value), .cfg_threshold(cfg_threshold),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_eol(out_eol), .out_eof(out_eof), .busy(busy), .ctrl_done(ctrl_done)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic straight from the operation rules.
  function automatic logic [BW-1:0] model_beat(input logic [BW-1:0] d, input int mode,
                                               input int val, input int thr);
    logic [BW-1:0] res;
    int r, g, b, grey;
    res = '0;
    for (int p = 0; p < PPC; p++) begin
      r = int'(d[p*24+16 +: 8]);
      g = int'(d[p*24+8 +: 8]);
      b = int'(d[p*24 +: 8]);
      grey = (r + g + b) / 3;
      case (mode)
        1: begin
          r = (r + val > 255) ? 255 : r + val;
          g = (g + val > 255) ? 255 : g + val;
          b = (b + val > 255) ? 255 : b + val;
        end
        2: begin
          r = (r - val < 0) ? 0 : r - val;
          g = (g - val < 0) ? 0 : g - val;
          b = (b - val < 0) ? 0 : b - val;
        end
        3: begin r = 255 - grey; g = r; b = r; end
        4: begin r = (grey > thr) ? 255 : 0; g = r; b = r; end
        default: ;
      endcase
      res[p*24 +: 24] = {r[7:0], g[7:0], b[7:0]};
    end
    return res;
  endfunction

  // pat: 0 incrementing bytes, 1 random, 2 every pixel = fix_pix.
  task automatic run_frame(input int mode, input int val, input int thr, input int pat,
                           input bit bp, input bit gaps, input bit ctl_noise,
                           input logic [23:0] fix_pix, input logic [23:0] fix_exp,
                           input bit use_fix, input bit chk_lat);
    logic [BW-1:0] beats [BEATS];
    logic [BW-1:0] prev_data;
    logic          prev_eol, prev_eof;
    bit            prev_stall, done_seen;
    int            sent, got;
    exp_t          q[$];
    exp_t          e;
    prev_data = '0; prev_eol = 1'b0; prev_eof = 1'b0;
    prev_stall = 1'b0; done_seen = 1'b0; sent = 0; got = 0;
    for (int i = 0; i < BEATS; i++) begin
      for (int j = 0; j < BW/8; j++) begin
        case (pat)
          0:       beats[i][j*8 +: 8] = 8'(i*(BW/8) + j);
          1:       beats[i][j*8 +: 8] = 8'($urandom);
          default: beats[i][j*8 +: 8] = fix_pix[(j%3)*8 +: 8];
        endcase
      end
    end
    @(posedge HCLK); #1;
    start = 1'b1; cfg_mode = 3'(mode); cfg_value = 8'(val); cfg_threshold = 8'(thr);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      @(posedge HCLK); #1;
      start     = 1'b0;
      in_valid  = (sent < BEATS) && (!gaps || $urandom_range(0, 3) != 0);
      in_data   = (sent < BEATS) ? beats[sent] : '0;
      out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (ctl_noise && sent < BEATS) begin
        start = 1'($urandom_range(0, 1));
        cfg_mode = 3'($urandom); cfg_value = 8'($urandom); cfg_threshold = 8'($urandom);
      end
      @(negedge HCLK);
      if (cyc == 0) check_val("busy_run", busy, 1);
      if (prev_stall) begin
        check_val("hold_data", out_data, prev_data);
        check_val("hold_eol", out_eol, prev_eol);
        check_val("hold_eof", out_eof, prev_eof);
      end
      if (out_valid && !out_ready) check_val("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_val("extra_beat", 1, 0);
        end else begin
          e = q.pop_front();
          check_val("data", out_data, e.data);
          check_val("eol", out_eol, e.eol);
          check_val("eof", out_eof, e.eof);
          check_val("ctrl_done", ctrl_done, e.eof);
          if (chk_lat) check_val("latency", 64'(cyc - e.cyc), 2);
          if (use_fix && got == 0) check_val("fixed_pix", out_data[23:0], fix_exp);
          $display("mode %0d beat %0d out=%h eol=%0b eof=%0b", mode, got, out_data, out_eol, out_eof);
          got++;
          if (e.eof) done_seen = 1'b1;
        end
      end else begin
        check_val("done_quiet", ctrl_done, 0);
      end
      if (in_valid && in_ready) begin
        if (sent >= BEATS) begin
          check_val("extra_accept", 1, 0);
        end else begin
          e.data = model_beat(beats[sent], mode, val, thr);
          e.eol  = (sent % BPL) == BPL-1;
          e.eof  = sent == BEATS-1;
          e.cyc  = cyc;
          q.push_back(e);
          sent++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data; prev_eol = out_eol; prev_eof = out_eof;
    end
    if (!done_seen) check_val("frame_timeout", 0, 1);
    check_val("beat_count", 64'(got), 64'(BEATS));
    @(posedge HCLK); #1;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge HCLK);
    check_val("busy_after", busy, 0);
    check_val("in_ready_idle", in_ready, 0);
  endtask

  initial begin
    #12;
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_eol_eof", {out_eol, out_eof}, 0);
    check_val("rst_busy_done", {busy, ctrl_done}, 0);
    @(posedge HCLK); #1 HRESETn = 1'b1;

    run_frame(0, 0, 0, 0, 0, 0, 0, 24'h0, 24'h0, 0, 1);
    run_frame(1, 100, 0, 2, 0, 0, 0, {8'd200, 8'd155, 8'd10}, {8'd255, 8'd255, 8'd110}, 1, 1);
    run_frame(2, 100, 0, 2, 0, 0, 0, {8'd50, 8'd100, 8'd101}, {8'd0, 8'd0, 8'd1}, 1, 1);
    run_frame(3, 0, 0, 2, 0, 0, 0, {8'd10, 8'd20, 8'd31}, {8'd235, 8'd235, 8'd235}, 1, 1);
    run_frame(4, 0, 90, 2, 0, 0, 0, {8'd90, 8'd90, 8'd92}, 24'h000000, 1, 1);
    run_frame(4, 0, 90, 2, 0, 0, 0, {8'd91, 8'd91, 8'd91}, 24'hFFFFFF, 1, 1);
    run_frame(3, 0, 0, 1, 1, 0, 1, 24'h0, 24'h0, 0, 0);
    for (int k = 0; k < 12; k++)
      run_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), 1, 1, 1, 0, 24'h0, 24'h0, 0, 0);

    // Abort a frame after three accepted beats.
    @(posedge HCLK); #1;
    start = 1'b1; cfg_mode = 3'd0;
    @(posedge HCLK); #1;
    start = 1'b0; in_valid = 1'b1; in_data = {$urandom, $urandom}; out_ready = 1'b1;
    repeat (3) @(posedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    check_val("abort_out_valid", out_valid, 0);
    check_val("abort_out_data", out_data, 0);
    check_val("abort_in_ready", in_ready, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_flags", {out_eol, out_eof, ctrl_done}, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    run_frame(1, 37, 0, 1, 0, 0, 0, 24'h0, 24'h0, 0, 1);
    run_frame(2, 60, 0, 1, 1, 1, 0, 24'h0, 24'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
